// File: rtl/cpu_multiciclo_pkg.sv
// cpu_multiciclo_pkg: shared opcode constants, FSM state encoding and a
// small opcode helper for the multi-cycle accumulator CPU.
package cpu_multiciclo_pkg;

  // 3-bit opcodes carried in the top bits of each instruction word
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDX  = 3'b001;
  localparam logic [2:0] OP_LDY  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OUT  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // True for the two opcodes that can overflow
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // True for every opcode whose result comes from the ALU
  function automatic logic uses_alu(input logic [2:0] op);
    return is_arith(op) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/cpu_multiciclo_if.sv
// cpu_multiciclo_if: instruction fetch bus between the CPU (master) and the
// program memory (slave). A word is transferred on any cycle where both
// instr_req and instr_valid are high.
interface cpu_multiciclo_if #(
  parameter int DATA_W     = 4,
  parameter int PROG_DEPTH = 16
);
  localparam int PC_W = $clog2(PROG_DEPTH);

  logic              instr_req;
  logic [PC_W-1:0]   instr_addr;
  logic              instr_valid;
  logic [DATA_W+2:0] instr_data;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_valid,
    input  instr_data
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_valid,
    output instr_data
  );

endinterface

// File: rtl/cpu_multiciclo_alu.sv
// cpu_multiciclo_alu: combinational datapath for ADD, SUB and AND.
// Optional macro CPU_MULTICICLO_SAT_EN: when defined, ADD/SUB clamp to the
// signed range on overflow instead of wrapping; overflow is reported either way.
module cpu_multiciclo_alu
  import cpu_multiciclo_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic [2:0]               op,
  output logic signed [DATA_W-1:0] result,
  output logic                     overflow
);

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] ext;

  // One extra bit of precision: overflow shows up as the two top bits disagreeing
  always_comb begin
    ext      = '0;
    result   = y;
    overflow = 1'b0;
    case (op)
      OP_ADD:  ext = {x[DATA_W-1], x} + {y[DATA_W-1], y};
      OP_SUB:  ext = {x[DATA_W-1], x} - {y[DATA_W-1], y};
      default: ext = '0;
    endcase
    if (is_arith(op)) begin
      overflow = ext[DATA_W] ^ ext[DATA_W-1];
      result   = ext[DATA_W-1:0];
`ifdef CPU_MULTICICLO_SAT_EN
      if (overflow) begin
        result = ext[DATA_W] ? MIN_NEG : MAX_POS;
      end
`endif
    end else if (op == OP_AND) begin
      result = x & y;
    end
  end

endmodule

// File: rtl/cpu_multiciclo.sv
// cpu_multiciclo: two-register multi-cycle CPU. Each instruction takes a
// FETCH phase (waits for instr_valid) and one EXEC phase; results land at
// the end of EXEC. Z is written by OUT and flagged with a one-cycle
// out_valid pulse aligned with the new Z value on the output.
// Optional macro CPU_MULTICICLO_SAT_EN selects saturating ADD/SUB (see ALU).
module cpu_multiciclo
  import cpu_multiciclo_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  cpu_multiciclo_if.master         bus,
  output logic [2:0]               Opcode,
  output logic signed [DATA_W-1:0] outx,
  output logic signed [DATA_W-1:0] outy,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     status,
  output logic                     busy,
  output logic                     halted
);

  localparam int PC_W = $clog2(PROG_DEPTH);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);

  state_t                   state;
  logic [PC_W-1:0]          pc;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] alu_result;
  logic                     alu_ovf;
  logic [PC_W-1:0]          pc_next;

  cpu_multiciclo_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .x        (outx),
    .y        (outy),
    .op       (Opcode),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  // Sequential PC with explicit wrap so non-power-of-two depths also work
  always_comb begin
    pc_next = (pc == PC_LAST) ? '0 : pc + 1'b1;
  end

  assign bus.instr_addr = pc;

  // Control FSM; every status output is registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pc            <= '0;
      imm           <= '0;
      Opcode        <= OP_NOP;
      outx          <= '0;
      outy          <= '0;
      out           <= '0;
      status        <= 1'b0;
      out_valid     <= 1'b0;
      bus.instr_req <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_FETCH;
            pc            <= '0;
            bus.instr_req <= 1'b1;
            busy          <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.instr_valid) begin
            Opcode        <= bus.instr_data[DATA_W+2:DATA_W];
            imm           <= bus.instr_data[DATA_W-1:0];
            state         <= ST_EXEC;
            bus.instr_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (uses_alu(Opcode)) begin
            outy   <= alu_result;
            status <= alu_ovf;
          end else if (Opcode == OP_LDX) begin
            outx <= imm;
          end else if (Opcode == OP_LDY) begin
            outy <= imm;
          end else if (Opcode == OP_OUT) begin
            out       <= outy;
            out_valid <= 1'b1;
          end
          if (Opcode == OP_HALT) begin
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state         <= ST_FETCH;
            pc            <= pc_next;
            bus.instr_req <= 1'b1;
          end
        end
        ST_HALT: begin
          if (start) begin
            state         <= ST_FETCH;
            pc            <= '0;
            outx          <= '0;
            outy          <= '0;
            out           <= '0;
            status        <= 1'b0;
            halted        <= 1'b0;
            busy          <= 1'b1;
            bus.instr_req <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multiciclo.sv
// tb_cpu_multiciclo: table of single-operation programs, hand sequences for
// fetch stalls, PC wrap and reset during EXEC, and random programs compared
// against an integer-arithmetic reference model.
module tb_cpu_multiciclo;
  import cpu_multiciclo_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int MAXV  = (1 << (DW - 1)) - 1;
  localparam int MINV  = -(1 << (DW - 1));
  localparam int BOUND = 2000;

  typedef struct {
    int         a;
    int         b;
    logic [2:0] op;
    int         exp_y;
    int         exp_st;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [2:0]        Opcode;
  logic signed [DW-1:0] outx, outy, out;
  logic              out_valid, status, busy, halted;

  cpu_multiciclo_if #(.DATA_W(DW), .PROG_DEPTH(DEPTH)) bus ();

  cpu_multiciclo #(.DATA_W(DW), .PROG_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .Opcode    (Opcode),
    .outx      (outx),
    .outy      (outy),
    .out       (out),
    .out_valid (out_valid),
    .status    (status),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [DW+2:0] prog [64];
  int          addr_log [64];
  int          fetch_idx = 0;
  int          fetch_delay = 0;
  bit          noise_en = 1'b0;
  int          out_pulses = 0;
  vec_t        vecs [11];

  // Program memory: serves words in fetch order after fetch_delay stall cycles
  initial begin : responder
    int wait_cnt;
    wait_cnt        = 0;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.instr_req) begin
        if (wait_cnt >= fetch_delay && fetch_idx < 64) begin
          bus.instr_valid     = 1'b1;
          bus.instr_data      = prog[fetch_idx];
          addr_log[fetch_idx] = int'(bus.instr_addr);
          fetch_idx           = fetch_idx + 1;
          wait_cnt            = 0;
        end else begin
          bus.instr_valid = 1'b0;
          bus.instr_data  = (DW+3)'($urandom);
          wait_cnt        = wait_cnt + 1;
        end
      end else begin
        wait_cnt        = 0;
        bus.instr_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.instr_data  = (DW+3)'($urandom);
      end
    end
  end

  // Counts cycles with out_valid high
  initial begin : pulse_monitor
    forever begin
      @(negedge clk);
      if (out_valid) out_pulses = out_pulses + 1;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Starts the loaded program and waits (bounded) for HALT
  task automatic apply_stimulus(input int delay, input bit glitch, output int cycles);
    fetch_idx   = 0;
    fetch_delay = delay;
    out_pulses  = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!halted && cycles < BOUND) begin
      @(negedge clk);
      cycles = cycles + 1;
      start  = glitch && (cycles == 3) && !halted;
    end
    start = 1'b0;
    check_output("halt_reached", int'(halted), 1);
  endtask

  function automatic int wrap_or_sat(input int t);
`ifdef CPU_MULTICICLO_SAT_EN
    if (t > MAXV) return MAXV;
    if (t < MINV) return MINV;
    return t;
`else
    return (((t - MINV) % (1 << DW)) + (1 << DW)) % (1 << DW) + MINV;
`endif
  endfunction

  // Reference model: interprets the program with plain integer arithmetic
  task automatic model_run(output int mx, output int my, output int mz,
                           output int mst, output int nout, output int ninstr);
    int t;
    logic [2:0] op;
    logic signed [DW-1:0] immv;
    mx = 0; my = 0; mz = 0; mst = 0; nout = 0; ninstr = 0;
    for (int i = 0; i < 64; i++) begin
      op     = prog[i][DW+2:DW];
      immv   = prog[i][DW-1:0];
      ninstr = ninstr + 1;
      if (op == OP_HALT) break;
      case (op)
        OP_LDX: mx = int'(immv);
        OP_LDY: my = int'(immv);
        OP_ADD: begin t = mx + my; mst = (t > MAXV || t < MINV) ? 1 : 0; my = wrap_or_sat(t); end
        OP_SUB: begin t = mx - my; mst = (t > MAXV || t < MINV) ? 1 : 0; my = wrap_or_sat(t); end
        OP_AND: begin my = mx & my; mst = 0; end
        OP_OUT: begin mz = my; nout = nout + 1; end
        default: ;
      endcase
    end
  endtask

  function automatic int addr_errors(input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (addr_log[i] != (i % DEPTH)) bad = bad + 1;
    return bad;
  endfunction

  initial begin : main
    int cycles, mx, my, mz, mst, nout, ninstr, n, d;

    vecs[0]  = '{3, 2, OP_ADD, 5, 0};
`ifdef CPU_MULTICICLO_SAT_EN
    vecs[1]  = '{7, 1, OP_ADD, 7, 1};
    vecs[2]  = '{-8, 1, OP_SUB, -8, 1};
    vecs[3]  = '{-8, -8, OP_ADD, -8, 1};
    vecs[6]  = '{7, -8, OP_SUB, 7, 1};
    vecs[7]  = '{-8, -1, OP_ADD, -8, 1};
`else
    vecs[1]  = '{7, 1, OP_ADD, -8, 1};
    vecs[2]  = '{-8, 1, OP_SUB, 7, 1};
    vecs[3]  = '{-8, -8, OP_ADD, 0, 1};
    vecs[6]  = '{7, -8, OP_SUB, -1, 1};
    vecs[7]  = '{-8, -1, OP_ADD, 7, 1};
`endif
    vecs[4]  = '{5, 3, OP_AND, 1, 0};
    vecs[5]  = '{-1, -1, OP_SUB, 0, 0};
    vecs[8]  = '{2, -3, OP_ADD, -1, 0};
    vecs[9]  = '{-3, 4, OP_SUB, -7, 0};
    vecs[10] = '{-2, -3, OP_AND, -4, 0};

    rst_n = 1'b1;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_halted", int'(halted), 0);
    check_output("rst_instr_req", int'(bus.instr_req), 0);
    check_output("rst_outx", int'(outx), 0);
    check_output("rst_outy", int'(outy), 0);
    check_output("rst_out", int'(out), 0);
    check_output("rst_opcode", int'(Opcode), 0);
    check_output("rst_status", int'(status), 0);
    check_output("rst_out_valid", int'(out_valid), 0);
    check_output("rst_addr", int'(bus.instr_addr), 0);
    #20 rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      prog[0] = {OP_LDX, DW'(vecs[v].a)};
      prog[1] = {OP_LDY, DW'(vecs[v].b)};
      prog[2] = {vecs[v].op, DW'(0)};
      prog[3] = {OP_OUT, DW'(0)};
      prog[4] = {OP_HALT, DW'(0)};
      apply_stimulus(0, 1'b0, cycles);
      check_output($sformatf("vec%0d_outy", v), int'(outy), vecs[v].exp_y);
      check_output($sformatf("vec%0d_out", v), int'(out), vecs[v].exp_y);
      check_output($sformatf("vec%0d_status", v), int'(status), vecs[v].exp_st);
      check_output($sformatf("vec%0d_outx", v), int'(outx), vecs[v].a);
      check_output($sformatf("vec%0d_cycles", v), cycles, 10);
      check_output($sformatf("vec%0d_pulses", v), out_pulses, 1);
      check_output($sformatf("vec%0d_opcode", v), int'(Opcode), int'(OP_HALT));
      check_output($sformatf("vec%0d_busy", v), int'(busy), 0);
    end

    // Three stall cycles per fetch with noise on instr_valid outside FETCH
    noise_en = 1'b1;
    prog[0] = {OP_LDX, DW'(3)};
    prog[1] = {OP_LDY, DW'(2)};
    prog[2] = {OP_ADD, DW'(0)};
    prog[3] = {OP_OUT, DW'(0)};
    prog[4] = {OP_HALT, DW'(0)};
    apply_stimulus(3, 1'b0, cycles);
    check_output("stall_out", int'(out), 5);
    check_output("stall_cycles", cycles, 25);
    check_output("stall_pulses", out_pulses, 1);
    check_output("stall_status", int'(status), 0);
    check_output("stall_opcode", int'(Opcode), int'(OP_HALT));

    // AND after an overflowing SUB clears status
    prog[0] = {OP_LDX, DW'(-8)};
    prog[1] = {OP_LDY, DW'(1)};
    prog[2] = {OP_SUB, DW'(0)};
    prog[3] = {OP_AND, DW'(0)};
    prog[4] = {OP_OUT, DW'(0)};
    prog[5] = {OP_HALT, DW'(0)};
    apply_stimulus(0, 1'b0, cycles);
`ifdef CPU_MULTICICLO_SAT_EN
    check_output("and_outy", int'(outy), -8);
`else
    check_output("and_outy", int'(outy), 0);
`endif
    check_output("and_status", int'(status), 0);
    check_output("and_cycles", cycles, 12);

    // Sixteen NOPs, then the PC wraps to 0 where HALT is served
    for (int i = 0; i < 16; i++) prog[i] = {OP_NOP, DW'(i)};
    prog[16] = {OP_HALT, DW'(0)};
    apply_stimulus(0, 1'b0, cycles);
    check_output("wrap_addr15", addr_log[15], 15);
    check_output("wrap_addr16", addr_log[16], 0);
    check_output("wrap_cycles", cycles, 34);
    check_output("wrap_addr_seq", addr_errors(17), 0);

    // Reset asserted while ADD is in EXEC
    prog[0] = {OP_LDX, DW'(3)};
    prog[1] = {OP_LDY, DW'(2)};
    prog[2] = {OP_ADD, DW'(0)};
    prog[3] = {OP_OUT, DW'(0)};
    prog[4] = {OP_HALT, DW'(0)};
    fetch_idx   = 0;
    fetch_delay = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("mid_opcode", int'(Opcode), int'(OP_ADD));
    check_output("mid_outy", int'(outy), 2);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_outy", int'(outy), 0);
    check_output("mid_rst_outx", int'(outx), 0);
    check_output("mid_rst_busy", int'(busy), 0);
    check_output("mid_rst_req", int'(bus.instr_req), 0);
    check_output("mid_rst_opcode", int'(Opcode), 0);
    check_output("mid_rst_addr", int'(bus.instr_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_rst_outy", int'(outy), 0);
    check_output("post_rst_busy", int'(busy), 0);

    // Random programs against the reference model, with a start glitch while busy
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) prog[i] = {3'($urandom_range(0, 6)), DW'($urandom)};
      prog[n] = {OP_HALT, DW'($urandom)};
      d = $urandom_range(0, 2);
      apply_stimulus(d, 1'b1, cycles);
      model_run(mx, my, mz, mst, nout, ninstr);
      check_output($sformatf("rnd%0d_x", r), int'(outx), mx);
      check_output($sformatf("rnd%0d_y", r), int'(outy), my);
      check_output($sformatf("rnd%0d_z", r), int'(out), mz);
      check_output($sformatf("rnd%0d_status", r), int'(status), mst);
      check_output($sformatf("rnd%0d_pulses", r), out_pulses, nout);
      check_output($sformatf("rnd%0d_cycles", r), cycles, ninstr * (2 + d));
      check_output($sformatf("rnd%0d_addr", r), addr_errors(ninstr), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
